flash_cmd_ctrl: RTL

Parametrised flash command controller for the board's 16-bit NOR flash, in CPU word mode: BYTE#=1, CE# low, RP# high, VPEN high. It sits between the memory arbiter and the flash pins. It serves word reads, word programs and, optionally, block erases through a valid/ready request port and a one-cycle response pulse. All bus-phase widths are set by a parameter. Program and erase completion is detected by status-register polling, with a timeout.

---
 rtl/flash_cmd_ctrl.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/flash_cmd_ctrl.sv
`timescale 1ns/1ps
// flash_cmd_ctrl: word read / word program / optional block erase controller
// for a 16-bit NOR flash in CPU word mode (BYTE#=1, CE# low, RP# high, VPEN high).
// Program and erase completion is found by polling the status register, with a
// poll-count timeout. Every bus phase lasts PHASE_CYC clocks.
// Optional feature macro: FLASH_CTRL_ERASE_EN (op 2'b10 = block erase; when
// undefined, op 2'b10 is rejected as illegal).
module flash_cmd_ctrl #(
    parameter int unsigned PHASE_CYC = 4,
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic [7:0]        rsp_status,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W:0]   flash_addr,
    inout  wire  [15:0]       flash_data,
    output logic              flash_byte,
    output logic              flash_vpen,
    output logic              flash_rp,
    output logic              flash_ce,
    output logic              flash_oe,
    output logic              flash_we
);

    localparam int unsigned PH_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
`ifdef FLASH_CTRL_ERASE_EN
    localparam logic [1:0] OP_ERASE = 2'b10;
`endif

    localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;
    localparam logic [15:0] CMD_PROG       = 16'h0040;
`ifdef FLASH_CTRL_ERASE_EN
    localparam logic [15:0] CMD_ERASE      = 16'h0020;
`endif
    localparam logic [15:0] CMD_CONFIRM    = 16'h00D0;
    localparam logic [15:0] CMD_CLR_SR     = 16'h0050;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WCMD,
        S_WREC1,
        S_WDATA,
        S_WREC2,
        S_RD,
        S_POLL,
        S_GAP,
        S_CLR,
        S_CLRREC,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PH_W-1:0]        phase_cnt;
    logic [PH_W-1:0]        phase_cnt_d;
    logic [TIMEOUT_W-1:0]   poll_cnt;
    logic [TIMEOUT_W-1:0]   poll_cnt_d;
    logic [TIMEOUT_W-1:0]   poll_inc;
    logic [1:0]             op_q;
    logic [15:0]            wdata_q;
    logic [7:0]             sr_q;
    logic [15:0]            dout_q;
    logic [15:0]            dout_d;
    logic                   doe_q;
    logic                   doe_d;
    logic                   oe_d;
    logic                   we_d;
    logic                   rsp_err_d;
    logic                   rsp_tmo_d;
    logic                   phase_last;
    logic                   accept;
    logic                   sr_err;

    // Tie-offs for CPU word mode with the device permanently selected and unlocked.
    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b1;
    assign flash_rp   = 1'b1;
    assign flash_ce   = 1'b0;

    // Data bus is driven only while a write command or its recovery is in progress.
    assign flash_data = doe_q ? dout_q : 16'hzzzz;

    assign phase_last = (phase_cnt == PH_W'(PHASE_CYC - 1));
    assign accept     = (state == S_IDLE) && cmd_valid;
    assign sr_err     = sr_q[5] | sr_q[4] | sr_q[3] | sr_q[1];
    assign poll_inc   = poll_cnt + TIMEOUT_W'(1);

    // Next-state, next bus values and response flags.
    always_comb begin
        state_next = state;
        poll_cnt_d = poll_cnt;
        dout_d     = dout_q;
        rsp_err_d  = 1'b0;
        rsp_tmo_d  = 1'b0;

        case (state)
            S_IDLE: begin
                poll_cnt_d = '0;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_READ: begin
                            state_next = S_WCMD;
                            dout_d     = CMD_READ_ARRAY;
                        end
                        OP_PROG: begin
                            state_next = S_WCMD;
                            dout_d     = CMD_PROG;
                        end
`ifdef FLASH_CTRL_ERASE_EN
                        OP_ERASE: begin
                            state_next = S_WCMD;
                            dout_d     = CMD_ERASE;
                        end
`endif
                        default: begin
                            state_next = S_DONE;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_WCMD: begin
                if (phase_last) state_next = S_WREC1;
            end
            S_WREC1: begin
                if (phase_last) begin
                    if (op_q == OP_READ) begin
                        state_next = S_RD;
                    end else begin
                        state_next = S_WDATA;
                        dout_d     = (op_q == OP_PROG) ? wdata_q : CMD_CONFIRM;
                    end
                end
            end
            S_WDATA: begin
                if (phase_last) state_next = S_WREC2;
            end
            S_WREC2: begin
                if (phase_last) state_next = S_POLL;
            end
            S_RD: begin
                if (phase_last) state_next = S_DONE;
            end
            S_POLL: begin
                if (phase_last) state_next = S_GAP;
            end
            S_GAP: begin
                if (phase_last) begin
                    if (!sr_q[7]) begin
                        poll_cnt_d = poll_inc;
                        if (poll_inc == '1) begin
                            state_next = S_DONE;
                            rsp_err_d  = 1'b1;
                            rsp_tmo_d  = 1'b1;
                        end else begin
                            state_next = S_POLL;
                        end
                    end else if (sr_err) begin
                        state_next = S_CLR;
                        dout_d     = CMD_CLR_SR;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_CLR: begin
                if (phase_last) state_next = S_CLRREC;
            end
            S_CLRREC: begin
                if (phase_last) begin
                    state_next = S_DONE;
                    rsp_err_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        oe_d  = !((state_next == S_RD) || (state_next == S_POLL));
        we_d  = !(state_next inside {S_WCMD, S_WDATA, S_CLR});
        doe_d = state_next inside {S_WCMD, S_WREC1, S_WDATA, S_WREC2, S_CLR, S_CLRREC};

        if ((state_next != state) || (state == S_IDLE)) begin
            phase_cnt_d = '0;
        end else begin
            phase_cnt_d = phase_cnt + PH_W'(1);
        end
    end

    // State register with phase and poll counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            poll_cnt  <= '0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_cnt_d;
            poll_cnt  <= poll_cnt_d;
        end
    end

    // Flash strobes and data-bus driver, registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flash_oe <= 1'b1;
            flash_we <= 1'b1;
            doe_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            flash_oe <= oe_d;
            flash_we <= we_d;
            doe_q    <= doe_d;
            dout_q   <= dout_d;
        end
    end

    // Request capture, status sampling and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= '0;
            wdata_q     <= '0;
            flash_addr  <= '0;
            sr_q        <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_status  <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= cmd_op;
                wdata_q    <= cmd_wdata;
                flash_addr <= {cmd_addr, 1'b0};
            end
            if ((state == S_POLL) && phase_last) begin
                sr_q <= flash_data[7:0];
            end
            rsp_valid <= (state_next == S_DONE);
            if (state_next == S_DONE) begin
                rsp_rdata   <= (state == S_RD) ? flash_data : 16'h0000;
                rsp_status  <= sr_q;
                rsp_err     <= rsp_err_d;
                rsp_timeout <= rsp_tmo_d;
            end
        end
    end

    // Handshake and activity flags, registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            cmd_ready <= (state_next == S_IDLE);
            busy      <= (state_next != S_IDLE);
        end
    end

endmodule
